uart_tx_buffered: RTL

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_fifo.sv | 51 +++++
 rtl/uart_tx_buffered.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit after bit 7.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Clocks per line bit, rounded to the nearest integer.
  function automatic int unsigned calc_div(input int unsigned freq, input int unsigned baud);
    return (freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular FIFO for the UART transmitter: storage, wrapping pointers, occupancy.
// The caller guarantees no push when full and no pop when empty.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;

  always_comb begin
    level_d = level_q;
    if (push_i && !pop_i)
      level_d = level_q + LW'(1);
    else if (pop_i && !push_i)
      level_d = level_q - LW'(1);
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered 8N1 UART transmitter with registered serial output.
// Build option: define UART_TX_PARITY_EN for 8E1 framing (even parity after bit 7).
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned FREQ  = 100000000,
  parameter int unsigned BAUD  = 115200,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   txd,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned DIV = calc_div(FREQ, BAUD);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned LW  = $clog2(DEPTH) + 1;

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          txd_q, txd_d;
  logic          rdy_q;
  logic          push, pop, bit_end, start_next;
  logic [7:0]    fifo_rdata;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  uart_tx_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .wdata_i(tx_data),
    .pop_i  (pop),
    .rdata_o(fifo_rdata),
    .level_o(level)
  );

  assign tx_ready = rdy_q && (level != LW'(DEPTH));
  assign push     = tx_valid && tx_ready;
  assign busy     = (state_q != IDLE) || (level != '0);
  assign txd      = txd_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    txd_d      = txd_q;
    pop        = 1'b0;
    start_next = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    bit_end = (cnt_q == CW'(DIV - 1));
    if (state_q != IDLE)
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);

    case (state_q)
      IDLE:  start_next = (level != '0);
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = '0;
        txd_d   = shreg_q[0];
      end
      DATA: if (bit_end) begin
        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
          txd_d   = par_q;
`else
          state_d = STOP;
          txd_d   = 1'b1;
`endif
        end else begin
          bit_d   = bit_q + 3'd1;
          shreg_d = shreg_q >> 1;
          txd_d   = shreg_q[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) begin
        state_d = STOP;
        txd_d   = 1'b1;
      end
`endif
      STOP: if (bit_end) begin
        if (level != '0) begin
          start_next = 1'b1;
        end else begin
          state_d = IDLE;
          txd_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // Shared by IDLE and end-of-STOP so back-to-back frames have no gap.
    if (start_next) begin
      pop     = 1'b1;
      state_d = START;
      txd_d   = 1'b0;
      cnt_d   = '0;
      shreg_d = fifo_rdata;
`ifdef UART_TX_PARITY_EN
      par_d   = ^fifo_rdata;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
      rdy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
      rdy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
